// File: rtl/seg14_pkg.sv
`default_nettype none
// ============================================================================
// Package : seg14_pkg -- character/glyph types and 14-segment glyph lookup
// Rev     : 1.0
// ============================================================================
package seg14_pkg;

   typedef logic [5:0]  char_t;
   typedef logic [13:0] glyph_t;
   typedef logic [3:0]  msg_addr_t;

   typedef enum logic [0:0] {
      SLOT_BLANK = 1'b0,
      SLOT_SHOW  = 1'b1
   } slot_state_t;

   localparam int     c_msg_len   = 16;
   localparam glyph_t GLYPH_SPACE = 14'h0000;

   // Bit order a,b,c,d,e,f,g1,g2,h,i,j,k,l,m (a = bit 13). h/j upper diagonals,
   // i/l centre verticals, k/m lower-left/lower-right diagonals.
   function automatic glyph_t glyph(input char_t c);
      case (c)
         6'd1:    glyph = 14'h3BC0; // A
         6'd2:    glyph = 14'h3C52; // B
         6'd3:    glyph = 14'h2700; // C
         6'd4:    glyph = 14'h3C12; // D
         6'd5:    glyph = 14'h2780; // E
         6'd6:    glyph = 14'h2380; // F
         6'd7:    glyph = 14'h2F40; // G
         6'd8:    glyph = 14'h1BC0; // H
         6'd9:    glyph = 14'h2412; // I
         6'd10:   glyph = 14'h1E00; // J
         6'd11:   glyph = 14'h0389; // K
         6'd12:   glyph = 14'h0700; // L
         6'd13:   glyph = 14'h1B28; // M
         6'd14:   glyph = 14'h1B21; // N
         6'd15:   glyph = 14'h3F00; // O
         6'd16:   glyph = 14'h33C0; // P
         6'd17:   glyph = 14'h3F01; // Q
         6'd18:   glyph = 14'h33C1; // R
         6'd19:   glyph = 14'h2DC0; // S
         6'd20:   glyph = 14'h2012; // T
         6'd21:   glyph = 14'h1F00; // U
         6'd22:   glyph = 14'h030C; // V
         6'd23:   glyph = 14'h1B05; // W
         6'd24:   glyph = 14'h002D; // X
         6'd25:   glyph = 14'h002A; // Y
         6'd26:   glyph = 14'h240C; // Z
         6'd27:   glyph = 14'h3F0C; // 0
         6'd28:   glyph = 14'h1808; // 1
         6'd29:   glyph = 14'h36C0; // 2
         6'd30:   glyph = 14'h3C40; // 3
         6'd31:   glyph = 14'h19C0; // 4
         6'd32:   glyph = 14'h2DC0; // 5
         6'd33:   glyph = 14'h2FC0; // 6
         6'd34:   glyph = 14'h3800; // 7
         6'd35:   glyph = 14'h3FC0; // 8
         6'd36:   glyph = 14'h3DC0; // 9
         default: glyph = GLYPH_SPACE;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg14_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : seg14_scan_ctrl_if -- host write/commit port of the message buffer
// Rev       : 1.0
// ============================================================================
interface seg14_scan_ctrl_if;
   import seg14_pkg::*;

   logic      wr_valid;
   logic      wr_ready;
   msg_addr_t wr_addr;
   char_t     wr_char;
   logic      commit;

   modport master (
      output wr_valid,
      output wr_addr,
      output wr_char,
      output commit,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_addr,
      input  wr_char,
      input  commit,
      output wr_ready
   );

endinterface
`default_nettype wire

// File: rtl/seg14_msg_buf.sv
`default_nettype none
// ============================================================================
// Module : seg14_msg_buf -- double-buffered 16-char message with commit copy
// Rev    : 1.0
// ============================================================================
module seg14_msg_buf
   import seg14_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      i_wr_en,
   input  msg_addr_t i_wr_addr,
   input  char_t     i_wr_char,
   input  logic      i_commit,
   input  logic      i_frame_end,
   output logic      o_pending,
   input  msg_addr_t i_rd_addr,
   output char_t     o_rd_char
);

   char_t r_shadow [c_msg_len];
   char_t r_active [c_msg_len];
   logic  r_pending;

   // Writes are blocked while pending, so a write never races the copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < c_msg_len; i++) begin
            r_shadow[i] <= '0;
            r_active[i] <= '0;
         end
         r_pending <= 1'b0;
      end else begin
         if (i_wr_en) begin
            r_shadow[i_wr_addr] <= i_wr_char;
         end
         if (i_frame_end && r_pending) begin
            for (int i = 0; i < c_msg_len; i++) begin
               r_active[i] <= r_shadow[i];
            end
            r_pending <= 1'b0;
         end else if (i_commit) begin
            r_pending <= 1'b1;
         end
      end
   end

   assign o_pending = r_pending;
   assign o_rd_char = r_active[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/seg14_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : seg14_scan_ctrl -- 14-segment digit scanner with blanking and scroll
// Rev    : 1.0
// ============================================================================
module seg14_scan_ctrl
   import seg14_pkg::*;
#(
   parameter int DIGITS        = 12,
   parameter int SCAN_DIV      = 1000,
   parameter int BLANK_CYC     = 16,
   parameter int SCROLL_FRAMES = 32
)(
   input  logic                clk,
   input  logic                rst_n,
   seg14_scan_ctrl_if.slave    host,
   input  logic                scroll_en,
   output logic [DIGITS-1:0]   sel,
   output glyph_t              segm,
   output logic                frame_tick
);

   // DIGITS must not exceed the 16-entry message; BLANK_CYC must be at least 1.
   localparam int c_slot_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int c_dig_w  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int c_frm_w  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

   localparam logic [c_slot_w-1:0] c_slot_last  = c_slot_w'(SCAN_DIV - 1);
   localparam logic [c_slot_w-1:0] c_blank_last = c_slot_w'(BLANK_CYC - 1);
   localparam logic [c_dig_w-1:0]  c_dig_last   = c_dig_w'(DIGITS - 1);
   localparam logic [c_frm_w-1:0]  c_frm_last   = c_frm_w'(SCROLL_FRAMES - 1);
   localparam logic [DIGITS-1:0]   c_sel_one    = DIGITS'(1);

   slot_state_t         r_state;
   logic [c_slot_w-1:0] r_slot;
   logic [c_dig_w-1:0]  r_digit;
   logic [DIGITS-1:0]   r_sel;
   glyph_t              r_segm;
   msg_addr_t           r_offset;
   logic [c_frm_w-1:0]  r_frm_cnt;

   logic      w_slot_wrap;
   logic      w_frame_end;
   logic      w_pending;
   logic      w_wr_en;
   msg_addr_t w_rd_addr;
   char_t     w_rd_char;

   assign w_slot_wrap   = (r_slot == c_slot_last);
   assign w_frame_end   = w_slot_wrap && (r_digit == c_dig_last);
   assign host.wr_ready = ~w_pending;
   assign w_wr_en       = host.wr_valid && ~w_pending;
   assign w_rd_addr     = scroll_en ? (msg_addr_t'(r_digit) + r_offset)
                                    : msg_addr_t'(r_digit);

   seg14_msg_buf u_msg_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_wr_en     (w_wr_en),
      .i_wr_addr   (host.wr_addr),
      .i_wr_char   (host.wr_char),
      .i_commit    (host.commit),
      .i_frame_end (w_frame_end),
      .o_pending   (w_pending),
      .i_rd_addr   (w_rd_addr),
      .o_rd_char   (w_rd_char)
   );

   // r_state tracks whether the current slot_cnt lies in the blank window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SLOT_BLANK;
         r_slot  <= '0;
         r_digit <= '0;
         r_sel   <= '0;
         r_segm  <= GLYPH_SPACE;
      end else begin
         r_slot <= w_slot_wrap ? '0 : r_slot + c_slot_w'(1);
         if (w_slot_wrap) begin
            r_digit <= (r_digit == c_dig_last) ? '0 : r_digit + c_dig_w'(1);
         end
         case (r_state)
            SLOT_BLANK: begin
               r_sel  <= '0;
               r_segm <= GLYPH_SPACE;
               if (r_slot == c_blank_last) begin
                  r_state <= SLOT_SHOW;
               end
            end
            SLOT_SHOW: begin
               r_sel  <= c_sel_one << r_digit;
               r_segm <= glyph(w_rd_char);
               if (w_slot_wrap) begin
                  r_state <= SLOT_BLANK;
               end
            end
            default: begin
               r_state <= SLOT_BLANK;
               r_sel   <= '0;
               r_segm  <= GLYPH_SPACE;
            end
         endcase
      end
   end

   // A commit landing at frame end restarts the scroll from the first character.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_offset  <= '0;
         r_frm_cnt <= '0;
      end else if (w_frame_end && w_pending) begin
         r_offset  <= '0;
         r_frm_cnt <= '0;
      end else if (!scroll_en) begin
         r_frm_cnt <= '0;
      end else if (w_frame_end) begin
         if (r_frm_cnt == c_frm_last) begin
            r_frm_cnt <= '0;
            r_offset  <= r_offset + 4'd1;
         end else begin
            r_frm_cnt <= r_frm_cnt + c_frm_w'(1);
         end
      end
   end

   assign sel        = r_sel;
   assign segm       = r_segm;
   assign frame_tick = w_frame_end;

endmodule
`default_nettype wire

// File: tb/tb_seg14_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_seg14_scan_ctrl -- self-checking bench for seg14_scan_ctrl
// Rev    : 1.0
// ============================================================================
module tb_seg14_scan_ctrl;

   localparam int DIGITS        = 12;
   localparam int SCAN_DIV      = 8;
   localparam int BLANK_CYC     = 2;
   localparam int SCROLL_FRAMES = 2;
   localparam int FRAME         = DIGITS * SCAN_DIV;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        scroll_en = 1'b0;
   logic [11:0] sel;
   logic [13:0] segm;
   logic        frame_tick;

   seg14_scan_ctrl_if host ();

   seg14_scan_ctrl #(
      .DIGITS        (DIGITS),
      .SCAN_DIV      (SCAN_DIV),
      .BLANK_CYC     (BLANK_CYC),
      .SCROLL_FRAMES (SCROLL_FRAMES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .host       (host),
      .scroll_en  (scroll_en),
      .sel        (sel),
      .segm       (segm),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model of the display state
   logic [5:0]  m_shadow [16];
   logic [5:0]  m_active [16];
   logic        m_pending;
   int          m_offset;
   int          m_fcnt;
   int          m_idx;
   int          m_last;
   logic [25:0] q_exp [$];

   // Only the codes this bench drives are listed; anything else yields X.
   function automatic logic [13:0] ref_glyph(input logic [5:0] c);
      case (c)
         6'd0:    ref_glyph = 14'h0000;
         6'd1:    ref_glyph = 14'h3BC0;
         6'd2:    ref_glyph = 14'h3C52;
         6'd3:    ref_glyph = 14'h2700;
         6'd4:    ref_glyph = 14'h3C12;
         6'd5:    ref_glyph = 14'h2780;
         6'd6:    ref_glyph = 14'h2380;
         6'd7:    ref_glyph = 14'h2F40;
         6'd8:    ref_glyph = 14'h1BC0;
         6'd9:    ref_glyph = 14'h2412;
         6'd10:   ref_glyph = 14'h1E00;
         6'd11:   ref_glyph = 14'h0389;
         6'd12:   ref_glyph = 14'h0700;
         6'd13:   ref_glyph = 14'h1B28;
         6'd14:   ref_glyph = 14'h1B21;
         6'd15:   ref_glyph = 14'h3F00;
         6'd16:   ref_glyph = 14'h33C0;
         6'd26:   ref_glyph = 14'h240C;
         6'd36:   ref_glyph = 14'h3DC0;
         default: ref_glyph = 14'hxxxx;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_shadow[i] = '0;
         m_active[i] = '0;
      end
      m_pending = 1'b0;
      m_offset  = 0;
      m_fcnt    = 0;
      m_idx     = 0;
      m_last    = 0;
      q_exp.delete();
   endtask

   // One clock: predict the post-edge outputs, advance the model, then compare.
   task automatic cyc();
      int          slot;
      int          d;
      int          a;
      logic [11:0] es;
      logic [13:0] eg;
      logic        tick;
      logic        acc;
      logic        pend0;
      logic [25:0] item;
      slot = m_idx % SCAN_DIV;
      d    = m_idx / SCAN_DIV;
      a    = scroll_en ? (d + m_offset) % 16 : d;
      es   = (slot >= BLANK_CYC) ? 12'(1) << d : 12'h000;
      eg   = (slot >= BLANK_CYC) ? ref_glyph(m_active[a]) : 14'h0000;
      q_exp.push_back({es, eg});
      tick = (m_idx == FRAME - 1);
      chk($sformatf("frame_tick@%0d", m_idx), {31'd0, frame_tick}, {31'd0, tick});
      chk($sformatf("wr_ready@%0d", m_idx), {31'd0, host.wr_ready}, {31'd0, ~m_pending});
      acc   = host.wr_valid && !m_pending;
      pend0 = m_pending;
      if (acc) m_shadow[host.wr_addr] = host.wr_char;
      if (tick && pend0) begin
         for (int i = 0; i < 16; i++) m_active[i] = m_shadow[i];
         m_offset  = 0;
         m_fcnt    = 0;
         m_pending = 1'b0;
      end else if (!scroll_en) begin
         m_fcnt = 0;
      end else if (tick) begin
         if (m_fcnt == SCROLL_FRAMES - 1) begin
            m_fcnt   = 0;
            m_offset = (m_offset + 1) % 16;
         end else begin
            m_fcnt = m_fcnt + 1;
         end
      end
      if (host.commit && !pend0) m_pending = 1'b1;
      m_last = m_idx;
      m_idx  = (m_idx + 1) % FRAME;
      @(posedge clk);
      #1;
      item = q_exp.pop_front();
      chk($sformatf("sel@%0d", m_last), {20'd0, sel}, {20'd0, item[25:14]});
      chk($sformatf("segm@%0d", m_last), {18'd0, segm}, {18'd0, item[13:0]});
      if (acc) host.wr_valid = 1'b0;
      host.commit = 1'b0;
   endtask

   task automatic host_write(input int addr, input int ch);
      host.wr_valid = 1'b1;
      host.wr_addr  = 4'(addr);
      host.wr_char  = 6'(ch);
      for (int n = 0; n < 3 * FRAME && host.wr_valid; n++) cyc();
      chk("write_accepted", {31'd0, host.wr_valid}, 32'd0);
      host.wr_valid = 1'b0;
   endtask

   task automatic do_commit();
      host.commit = 1'b1;
      cyc();
   endtask

   task automatic run_frames(input int n);
      repeat (n) begin
         do cyc(); while (m_idx != 0);
      end
   endtask

   // Advance to the middle of digit d's lit interval and check against a literal glyph.
   task automatic show_check(input int d, input logic [13:0] want, input string tag);
      int target;
      int n;
      target = d * SCAN_DIV + BLANK_CYC + 1;
      n      = 0;
      do begin
         cyc();
         n++;
      end while (m_last != target && n < 2 * FRAME);
      chk({tag, "_sel"}, {20'd0, sel}, {20'd0, 12'(1) << d});
      chk(tag, {18'd0, segm}, {18'd0, want});
   endtask

   initial begin
      host.wr_valid = 1'b0;
      host.wr_addr  = '0;
      host.wr_char  = '0;
      host.commit   = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sel", {20'd0, sel}, 32'd0);
      chk("rst_segm", {18'd0, segm}, 32'd0);
      chk("rst_tick", {31'd0, frame_tick}, 32'd0);
      chk("rst_ready", {31'd0, host.wr_ready}, 32'd1);
      rst_n = 1'b1;

      // Blank message: plain scan with blanking, 96-cycle frames
      run_frames(2);

      // HELLO
      host_write(0, 8);
      host_write(1, 5);
      host_write(2, 12);
      host_write(3, 12);
      host_write(4, 15);
      do_commit();
      run_frames(1);
      show_check(0, 14'h1BC0, "hello_H");
      show_check(1, 14'h2780, "hello_E");
      show_check(4, 14'h3F00, "hello_O");
      show_check(5, 14'h0000, "hello_space");
      run_frames(1);

      // Write and commit in the same cycle, then a repeat commit while pending
      host.wr_valid = 1'b1;
      host.wr_addr  = 4'd0;
      host.wr_char  = 6'd26;
      host.commit   = 1'b1;
      cyc();
      repeat (10) cyc();
      do_commit();
      run_frames(1);
      show_check(0, 14'h240C, "same_cycle_Z");
      run_frames(2);

      // Scroll over A..P
      for (int i = 0; i < 16; i++) host_write(i, i + 1);
      do_commit();
      run_frames(1);
      scroll_en = 1'b1;
      run_frames(2);
      show_check(0, 14'h3C52, "scroll_B");
      for (int k = 0; k < 40 && m_offset != 15; k++) run_frames(1);
      show_check(11, 14'h0389, "scroll_d11_K");
      for (int k = 0; k < 4 && m_offset != 0; k++) run_frames(1);
      show_check(0, 14'h3BC0, "scroll_wrap_A");
      scroll_en = 1'b0;
      run_frames(1);

      // Write held during pending lands after the copy
      do_commit();
      host_write(5, 36);
      run_frames(1);
      show_check(5, 14'h2380, "pend_excluded_F");
      do_commit();
      run_frames(1);
      show_check(5, 14'h3DC0, "pend_later_9");

      // Asynchronous reset in a lit slot with a commit pending
      host_write(2, 26);
      do_commit();
      repeat (40) cyc();
      for (int k = 0; k < SCAN_DIV && (m_last % SCAN_DIV) < BLANK_CYC; k++) cyc();
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_sel", {20'd0, sel}, 32'd0);
      chk("midrst_segm", {18'd0, segm}, 32'd0);
      chk("midrst_ready", {31'd0, host.wr_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
      run_frames(2);
      show_check(2, 14'h0000, "midrst_space");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
